// File: rtl/shift_reg_seq_ctrl.sv
// Sequencer that operates an external shift_reg as a byte serializer (TX)
// and a 1..WIDTH-bit deserializer (RX) between a valid/ready client and a serial link.
module shift_reg_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_msb_first_i,
  input  logic             rx_start_i,
  input  logic [CNT_W-1:0] rx_len_i,
  input  logic             rx_msb_first_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic             ser_en_o,
  output logic             rx_valid_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             busy_o,
  output logic [1:0]       sr_mode_o,
  output logic [WIDTH-1:0] sr_par_o,
  output logic             sr_d_o,
  input  logic [WIDTH-1:0] sr_p_i
);

  localparam logic [1:0] MODE_HOLD  = 2'd0;
  localparam logic [1:0] MODE_LOAD  = 2'd1;
  localparam logic [1:0] MODE_LEFT  = 2'd2;
  localparam logic [1:0] MODE_RIGHT = 2'd3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TX_SHIFT = 3'd1;
  localparam logic [2:0] S_RX_CLR   = 3'd2;
  localparam logic [2:0] S_RX_SHIFT = 3'd3;
  localparam logic [2:0] S_RX_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_WIDTH = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             msb_q, msb_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;

  // State and latched controls
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      len_q      <= '0;
      msb_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      len_q      <= len_d;
      msb_q      <= msb_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Next state and shift_reg control
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    msb_d      = msb_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    tx_ready_o = 1'b0;
    busy_o     = 1'b1;
    ser_o      = 1'b0;
    ser_en_o   = 1'b0;
    sr_mode_o  = MODE_HOLD;
    sr_par_o   = '0;
    sr_d_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (tx_valid_i) begin
          sr_mode_o = MODE_LOAD;
          sr_par_o  = tx_data_i;
          msb_d     = tx_msb_first_i;
          count_d   = '0;
          state_d   = S_TX_SHIFT;
        end else if (rx_start_i) begin
          // Out-of-range lengths (0 or above WIDTH) receive a full word
          len_d   = (rx_len_i == '0 || rx_len_i > CNT_WIDTH) ? CNT_WIDTH : rx_len_i;
          msb_d   = rx_msb_first_i;
          state_d = S_RX_CLR;
        end
      end

      S_TX_SHIFT: begin
        ser_en_o  = 1'b1;
        ser_o     = msb_q ? sr_p_i[WIDTH-1] : sr_p_i[0];
        sr_mode_o = msb_q ? MODE_LEFT : MODE_RIGHT;
        count_d   = count_q + CNT_ONE;
        if (count_q == CNT_LAST) begin
          count_d = '0;
          state_d = S_IDLE;
        end
      end

      S_RX_CLR: begin
        sr_mode_o = MODE_LOAD;
        count_d   = '0;
        state_d   = S_RX_SHIFT;
      end

      S_RX_SHIFT: begin
        sr_d_o    = ser_i;
        sr_mode_o = msb_q ? MODE_LEFT : MODE_RIGHT;
        count_d   = count_q + CNT_ONE;
        if (count_q == len_q - CNT_ONE) begin
          count_d = '0;
          state_d = S_RX_DONE;
        end
      end

      S_RX_DONE: begin
        // LSB-first words sit at the top of the register; right-justify them
        rx_data_d  = msb_q ? sr_p_i : (sr_p_i >> (CNT_WIDTH - len_q));
        rx_valid_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Scoreboard bench for shift_reg_seq_ctrl with a behavioural 8-bit shift_reg attached.
module tb_shift_reg_seq_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             nrst;
  logic             tx_valid_i;
  logic             tx_ready_o;
  logic [WIDTH-1:0] tx_data_i;
  logic             tx_msb_first_i;
  logic             rx_start_i;
  logic [CNT_W-1:0] rx_len_i;
  logic             rx_msb_first_i;
  logic             ser_i;
  logic             ser_o;
  logic             ser_en_o;
  logic             rx_valid_o;
  logic [WIDTH-1:0] rx_data_o;
  logic             busy_o;
  logic [1:0]       sr_mode_o;
  logic [WIDTH-1:0] sr_par_o;
  logic             sr_d_o;
  logic [WIDTH-1:0] sr_p;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic             ser_q[$];
  logic [WIDTH-1:0] rx_q[$];

  shift_reg_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
    .tx_msb_first_i(tx_msb_first_i),
    .rx_start_i(rx_start_i), .rx_len_i(rx_len_i), .rx_msb_first_i(rx_msb_first_i),
    .ser_i(ser_i), .ser_o(ser_o), .ser_en_o(ser_en_o),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .busy_o(busy_o),
    .sr_mode_o(sr_mode_o), .sr_par_o(sr_par_o), .sr_d_o(sr_d_o), .sr_p_i(sr_p)
  );

  always #5 clk = ~clk;

  // Behavioural shift_reg: HOLD/LOAD/LEFT(D->bit0)/RIGHT(D->bit7), same sync reset
  always @(posedge clk) begin
    if (!nrst) sr_p <= '0;
    else case (sr_mode_o)
      2'd1:    sr_p <= sr_par_o;
      2'd2:    sr_p <= {sr_p[WIDTH-2:0], sr_d_o};
      2'd3:    sr_p <= {sr_d_o, sr_p[WIDTH-1:1]};
      default: sr_p <= sr_p;
    endcase
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes expected serial bits and received words as the DUT presents them
  always @(negedge clk) begin
    if (mon_en) begin
      if (ser_en_o) begin
        if (ser_q.size() == 0) chk("ser_unexpected", 8'(ser_en_o), 8'd0);
        else chk("ser_o", 8'(ser_o), 8'(ser_q.pop_front()));
        chk("tx_ready_during_tx", 8'(tx_ready_o), 8'd0);
      end else begin
        chk("ser_o_idle_zero", 8'(ser_o), 8'd0);
      end
      if (rx_valid_o) begin
        if (rx_q.size() == 0) chk("rx_unexpected", 8'(rx_valid_o), 8'd0);
        else chk("rx_data", rx_data_o, rx_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [WIDTH-1:0] data, input logic msb);
    for (int i = 0; i < int'(WIDTH); i++)
      ser_q.push_back(msb ? data[WIDTH-1-i] : data[i]);
  endtask

  // Runs one receive; seq holds the bits in send order from bit n-1 down to bit 0
  task automatic do_rx(input logic [CNT_W-1:0] len, input logic msb, input int n,
                       input logic [15:0] seq, input logic [WIDTH-1:0] exp);
    rx_q.push_back(exp);
    rx_start_i = 1'b1; rx_len_i = len; rx_msb_first_i = msb;
    tick();
    rx_start_i = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      ser_i = seq[n-1-i];
      tick();
    end
    ser_i = 1'b0;
    chk("rx_valid_in_done", 8'(rx_valid_o), 8'd0);
    tick();
    chk("rx_valid_pulse", 8'(rx_valid_o), 8'd1);
    tick();
    chk("rx_valid_drop", 8'(rx_valid_o), 8'd0);
    chk("rx_data_hold", rx_data_o, exp);
  endtask

  initial begin
    nrst = 1'b0; tx_valid_i = 1'b1; tx_data_i = 8'hFF; tx_msb_first_i = 1'b1;
    rx_start_i = 1'b0; rx_len_i = '0; rx_msb_first_i = 1'b0; ser_i = 1'b0;

    // 1: reset with a pending TX word
    tick(); tick();
    chk("rst_tx_ready", 8'(tx_ready_o), 8'd1);
    chk("rst_busy", 8'(busy_o), 8'd0);
    chk("rst_rx_valid", 8'(rx_valid_o), 8'd0);
    chk("rst_rx_data", rx_data_o, 8'h00);
    chk("rst_sr_p", sr_p, 8'h00);
    nrst = 1'b1; tx_valid_i = 1'b0;
    mon_en = 1'b1;
    tick();

    // 2: TX 0x1E MSB-first
    push_tx(8'h1E, 1'b1);
    tx_valid_i = 1'b1; tx_data_i = 8'h1E; tx_msb_first_i = 1'b1;
    tick();
    tx_valid_i = 1'b0;
    repeat (WIDTH) tick();
    chk("tx2_ready_after", 8'(tx_ready_o), 8'd1);
    chk("tx2_bits_left", 8'(ser_q.size()), 8'd0);

    // 3: back-to-back words, LSB-first 0x1E then MSB-first 0x80
    push_tx(8'h1E, 1'b0);
    push_tx(8'h80, 1'b1);
    tx_valid_i = 1'b1; tx_data_i = 8'h1E; tx_msb_first_i = 1'b0;
    tick();
    tx_data_i = 8'h80; tx_msb_first_i = 1'b1;
    repeat (WIDTH) tick();
    chk("tx3_gap_busy", 8'(busy_o), 8'd0);
    chk("tx3_gap_ser_en", 8'(ser_en_o), 8'd0);
    tick();
    tx_valid_i = 1'b0;
    repeat (WIDTH) tick();
    chk("tx3_bits_left", 8'(ser_q.size()), 8'd0);

    // 4: RX 8 bits MSB-first, then a short RX that must not see the stale 0xAA
    do_rx(4'd8, 1'b1, 8, 16'b10101010, 8'hAA);
    chk("rx4_sr_p", sr_p, 8'hAA);
    do_rx(4'd3, 1'b1, 3, 16'b110, 8'h06);

    // 5: abort a TX after three bits, then RX 6 bits LSB-first
    ser_q.push_back(1'b1); ser_q.push_back(1'b0); ser_q.push_back(1'b1);
    tx_valid_i = 1'b1; tx_data_i = 8'hA5; tx_msb_first_i = 1'b1;
    tick();
    tx_valid_i = 1'b0;
    tick(); tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("abort_busy", 8'(busy_o), 8'd0);
    chk("abort_ser_en", 8'(ser_en_o), 8'd0);
    chk("abort_bits_left", 8'(ser_q.size()), 8'd0);
    tick();
    do_rx(4'd6, 1'b0, 6, 16'b101010, 8'h15);
    chk("rx5_sr_p", sr_p, 8'h54);

    // 6: TX wins over a simultaneous RX start; RX start during TX is dropped
    push_tx(8'h5A, 1'b1);
    tx_valid_i = 1'b1; tx_data_i = 8'h5A; tx_msb_first_i = 1'b1;
    rx_start_i = 1'b1; rx_len_i = 4'd4; rx_msb_first_i = 1'b1;
    tick();
    tx_valid_i = 1'b0;
    repeat (3) tick();
    rx_start_i = 1'b0;
    repeat (WIDTH - 3) tick();
    chk("tx6_ready_after", 8'(tx_ready_o), 8'd1);
    repeat (4) tick();
    chk("tx6_no_rx_busy", 8'(busy_o), 8'd0);
    chk("tx6_bits_left", 8'(ser_q.size()), 8'd0);
    do_rx(4'd0, 1'b1, 8, 16'b11001010, 8'hCA);

    repeat (3) tick();
    chk("rx_words_left", 8'(rx_q.size()), 8'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq_ctrl.md
Name: shift_reg_seq_ctrl

Overview:
Sequencer that drives the team's 8-bit shift_reg to operate it as a serializer (TX) and deserializer (RX). The shift_reg modes are HOLD=0, LOAD=1, LEFT=2 and RIGHT=3. In LEFT mode, D enters bit0 and data moves toward the MSB; in RIGHT mode, D enters bit7. This block owns shift_reg's mode_i, par_i and D inputs and observes its P output. It sits between a byte-wide client (valid/ready) and a 1-bit serial link.

Parameters:
WIDTH, 8, shift register width; must match shift_reg.
CNT_W, 4, bit-counter width, equal to clog2(WIDTH)+1.

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  synchronous active-low reset
tx_valid_i  in  1  TX word available
tx_ready_o  out  1  controller can accept a TX word
tx_data_i  in  WIDTH  word to serialize
tx_msb_first_i  in  1  1 = send MSB first (LEFT mode); 0 = LSB first (RIGHT mode)
rx_start_i  in  1  start a receive
rx_len_i  in  CNT_W  number of bits to receive, 1..WIDTH; 0 is treated as WIDTH
rx_msb_first_i  in  1  1 = first received bit is the MSB
ser_i  in  1  serial input bit
ser_o  out  1  serial output bit
ser_en_o  out  1  ser_o is valid this cycle
rx_valid_o  out  1  one-cycle pulse: rx_data_o is valid
rx_data_o  out  WIDTH  received word, right-justified
busy_o  out  1  controller not in IDLE
sr_mode_o  out  2  to shift_reg mode_i
sr_par_o  out  WIDTH  to shift_reg par_i
sr_d_o  out  1  to shift_reg D
sr_p_i  in  WIDTH  from shift_reg P

Behaviour:
- States: IDLE, TX_SHIFT, RX_CLR, RX_SHIFT, RX_DONE.
- Reset (nrst=0 at a rising edge): state=IDLE, count=0, rx_valid_o=0, rx_data_o=0, latched direction/length cleared. Reset mid-operation aborts immediately; no rx_valid_o pulse is produced. shift_reg is reset by the same nrst.
- Outputs are combinational from state and latched controls, except rx_data_o and rx_valid_o, which are registered.
- IDLE:
  - tx_ready_o=1, busy_o=0.
  - If tx_valid_i: sr_mode_o=LOAD, sr_par_o=tx_data_i.
  - Otherwise sr_mode_o=HOLD, sr_par_o=0, sr_d_o=0.
- TX handshake: tx_valid_i&&tx_ready_o at an edge loads shift_reg, latches tx_msb_first_i, sets count=0, next state TX_SHIFT.
- Priority: when tx_valid_i and rx_start_i are both high in IDLE, TX wins. rx_start_i is ignored (not queued) when not in IDLE.
- TX_SHIFT, WIDTH cycles:
  - ser_en_o=1; sr_d_o=0.
  - MSB-first: ser_o=sr_p_i[WIDTH-1], sr_mode_o=LEFT.
  - LSB-first: ser_o=sr_p_i[0], sr_mode_o=RIGHT.
  - count increments each cycle; at count==WIDTH-1, next state is IDLE.
  - tx_ready_o=0 throughout.
- TX timing: handshake edge, then WIDTH consecutive ser_en_o cycles, then IDLE. Back-to-back words therefore have 1 idle cycle between them.
- RX start: rx_start_i in IDLE with no tx_valid_i latches rx_len_i (0 becomes WIDTH) and rx_msb_first_i; next state RX_CLR.
- RX_CLR, 1 cycle: sr_mode_o=LOAD, sr_par_o=0, which clears stale contents. Next state RX_SHIFT, count=0.
- RX_SHIFT, len cycles:
  - sr_d_o=ser_i, sampled at each rising edge.
  - sr_mode_o=LEFT if MSB-first, RIGHT otherwise.
  - At count==len-1, next state is RX_DONE.
- RX_DONE, 1 cycle: sr_mode_o=HOLD. At the edge leaving RX_DONE:
  - rx_data_o = sr_p_i if MSB-first; sr_p_i >> (WIDTH-len) if LSB-first.
  - rx_valid_o=1 for exactly the following cycle.
  - Next state is IDLE.
- rx_data_o holds its value until the next RX completes.
- Count arithmetic is unsigned CNT_W bits and never wraps because it is bounded by WIDTH.
- ser_o=0 whenever ser_en_o=0.

Test Plan:
1. Reset with tx_valid_i=1, tx_data_i=8'hFF, held 2 cycles -> tx_ready_o=1, busy_o=0, rx_valid_o=0, rx_data_o=0, shift_reg P=0; no load occurs during reset.
2. TX 8'h1E MSB-first -> ser_en_o high for exactly 8 cycles with ser_o=0,0,0,1,1,1,1,0; tx_ready_o low during those cycles, high again after.
3. TX 8'h1E LSB-first, then immediately a second word 8'h80 MSB-first -> first word sends 0,1,1,1,1,0,0,0; one IDLE cycle; second word sends 1,0,0,0,0,0,0,0.
4. RX len=8 MSB-first, ser_i=1,0,1,0,1,0,1,0 -> rx_valid_o one-cycle pulse with rx_data_o=8'hAA, arriving 2 cycles after the last bit edge (RX_DONE, then the pulse).
5. Preload via TX abort (reset mid-TX after 3 bits), then RX len=6 LSB-first, ser_i=1,0,1,0,1,0 -> internal P=8'h54, rx_data_o=8'h15; no stale bits; after the reset, busy_o=0 and ser_en_o=0.
6. tx_valid_i and rx_start_i asserted together in IDLE -> TX proceeds; rx_start_i asserted during TX is ignored and no rx_valid_o pulse follows. RX with rx_len_i=0 -> 8 bits received.
